ebus_responder: RTL and testbench

EBUS_RESPONDER -- requirements
Module: ebus_responder

---
 rtl/ebus_pkg.sv | 43 ++++
 rtl/ebus_pi_encode.sv | 18 +
 rtl/ebus_responder.sv | 166 ++++++++++++++++
 tb/tb_ebus_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ebus_pkg.sv
// ebus_pkg: shared definitions for the EBUS responder.
//   ebus_word_t  - 36-bit EBUS word, bit 0 is the most significant bit
//   ebus_func_e  - function codes carried on ebus_func (1xx is reserved)
//   ebus_state_e - responder FSM states
//   bit positions of the CONO command fields and the CONI status fields
//   coni_word()  - assembles the CONI status word
package ebus_pkg;

    typedef logic [0:35] ebus_word_t;

    typedef enum logic [2:0] {
        FN_CONI  = 3'b000,
        FN_CONO  = 3'b001,
        FN_DATAI = 3'b010,
        FN_DATAO = 3'b011
    } ebus_func_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATCH   = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } ebus_state_e;

    localparam int CONO_CLR_DONE = 28;
    localparam int CONO_SET_DONE = 29;
    localparam int CONO_BUSY     = 30;
    localparam int CONI_BUSY     = 30;
    localparam int CONI_DONE     = 31;
    localparam int PIA_FIRST     = 33;
    localparam int PIA_LAST      = 35;

    function automatic ebus_word_t coni_word(input logic busy, input logic done,
                                             input logic [2:0] pia);
        ebus_word_t w;
        w                      = '0;
        w[CONI_BUSY]           = busy;
        w[CONI_DONE]           = done;
        w[PIA_FIRST:PIA_LAST]  = pia;
        return w;
    endfunction

endpackage

// File: rtl/ebus_pi_encode.sv
// ebus_pi_encode: turns a 3-bit PI assignment into a one-hot request vector.
//   pia_i  [2:0]  priority interrupt level, 0 means "no level assigned"
//   req_i         request condition
//   pi_o   [1:7]  one-hot request, pi_o[pia_i] while req_i and pia_i != 0
module ebus_pi_encode (
    input  logic [2:0] pia_i,
    input  logic       req_i,
    output logic [1:7] pi_o
);

    always_comb begin
        pi_o = '0;
        for (int i = 1; i <= 7; i++) begin
            pi_o[i] = req_i && (pia_i == 3'(i));
        end
    end

endmodule

// File: rtl/ebus_responder.sv
// ebus_responder: EBUS device responder with DATA and STATUS registers.
// Optional feature macro: EBUS_RESPONDER_PI_EN (drives pi_req from DONE/PIA).
//   clk, rst_n          clock, asynchronous active-low reset
//   ebus_cs      [6:0]  device select, answered when equal to DEV_NUM
//   ebus_func    [2:0]  CONI / CONO / DATAI / DATAO, 1xx ignored
//   ebus_demand         controller demand, high for the whole transaction
//   ebus_data_in [0:35] write data (CONO/DATAO)
//   ebus_xfer           transfer acknowledge (registered)
//   ebus_drive          responder drives ebus_data_out (registered)
//   ebus_data_out[0:35] read data, zero whenever ebus_drive is low (registered)
//   pi_req       [1:7]  one-hot PI request, zero unless EBUS_RESPONDER_PI_EN
//
// state      | meaning
// IDLE       | waiting for demand with a matching device select
// LATCH      | func/data captured; commit or abandon on next edge
// XFER       | acknowledge held until demand drops
// RELEASE    | acknowledge removed, one cycle before accepting a new demand
module ebus_responder
    import ebus_pkg::*;
#(
    parameter logic [6:0] DEV_NUM = 7'o040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  ebus_cs,
    input  logic [2:0]  ebus_func,
    input  logic        ebus_demand,
    input  logic [0:35] ebus_data_in,
    output logic        ebus_xfer,
    output logic        ebus_drive,
    output logic [0:35] ebus_data_out,
    output logic [1:7]  pi_req
);

    ebus_state_e state_q, state_d;
    logic [2:0]  func_q, func_d;
    ebus_word_t  wdata_q, wdata_d;
    ebus_word_t  data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  pia_q, pia_d;
    logic        xfer_q, xfer_d;
    logic        drive_q, drive_d;
    ebus_word_t  rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pia_d   = pia_q;
        xfer_d  = xfer_q;
        drive_d = drive_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (ebus_demand && (ebus_cs == DEV_NUM)) begin
                    state_d = ST_LATCH;
                    func_d  = ebus_func;
                    wdata_d = ebus_data_in;
                end
            end
            ST_LATCH: begin
                // Side effects commit only here, so a demand dropped during
                // LATCH or a reserved code leaves every register untouched.
                if (ebus_demand && !func_q[2]) begin
                    state_d = ST_XFER;
                    xfer_d  = 1'b1;
                    case (func_q)
                        FN_CONI: begin
                            drive_d = 1'b1;
                            rdata_d = coni_word(busy_q, done_q, pia_q);
                        end
                        FN_CONO: begin
                            if (wdata_q[CONO_CLR_DONE]) begin
                                done_d = 1'b0;
                            end else if (wdata_q[CONO_SET_DONE]) begin
                                done_d = 1'b1;
                            end
                            busy_d = wdata_q[CONO_BUSY];
                            pia_d  = wdata_q[PIA_FIRST:PIA_LAST];
                        end
                        FN_DATAI: begin
                            drive_d = 1'b1;
                            rdata_d = data_q;
                            done_d  = 1'b0;
                        end
                        FN_DATAO: begin
                            data_d = wdata_q;
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end
                        default: ;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!ebus_demand) begin
                    state_d = ST_RELEASE;
                    xfer_d  = 1'b0;
                    drive_d = 1'b0;
                    rdata_d = '0;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            func_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pia_q   <= '0;
            xfer_q  <= 1'b0;
            drive_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pia_q   <= pia_d;
            xfer_q  <= xfer_d;
            drive_q <= drive_d;
            rdata_q <= rdata_d;
        end
    end

    assign ebus_xfer     = xfer_q;
    assign ebus_drive    = drive_q;
    assign ebus_data_out = rdata_q;

`ifdef EBUS_RESPONDER_PI_EN
    logic [1:7] pi_d, pi_q;

    ebus_pi_encode u_pi_encode (
        .pia_i (pia_q),
        .req_i (done_q),
        .pi_o  (pi_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_q <= '0;
        end else begin
            pi_q <= pi_d;
        end
    end

    assign pi_req = pi_q;
`else
    assign pi_req = '0;
`endif

endmodule

// File: tb/tb_ebus_responder.sv
module tb_ebus_responder;

    localparam logic [6:0] DEV = 7'o040;

    logic        clk;
    logic        rst_n;
    logic [6:0]  ebus_cs;
    logic [2:0]  ebus_func;
    logic        ebus_demand;
    logic [0:35] ebus_data_in;
    logic        ebus_xfer;
    logic        ebus_drive;
    logic [0:35] ebus_data_out;
    logic [1:7]  pi_req;

    ebus_responder #(.DEV_NUM(DEV)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ebus_cs       (ebus_cs),
        .ebus_func     (ebus_func),
        .ebus_demand   (ebus_demand),
        .ebus_data_in  (ebus_data_in),
        .ebus_xfer     (ebus_xfer),
        .ebus_drive    (ebus_drive),
        .ebus_data_out (ebus_data_out),
        .pi_req        (pi_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        drive;
        logic [0:35] data;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // reference model of the responder registers
    logic        m_busy, m_done;
    logic [2:0]  m_pia;
    logic [0:35] m_data;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%o expected=%o", tag, obs, exp);
        end
    endtask

    function automatic logic [0:35] m_coni();
        return {30'b0, m_busy, m_done, 1'b0, m_pia};
    endfunction

    function automatic logic [1:7] m_pi();
        logic [1:7] r;
        r = '0;
`ifdef EBUS_RESPONDER_PI_EN
        for (int i = 1; i <= 7; i++) r[i] = m_done && (m_pia == i[2:0]);
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_pia  = '0;
        m_data = '0;
    endtask

    // push expected read-back and apply the register side effect to the model
    task automatic model_commit(input logic [2:0] fn, input logic [0:35] d);
        exp_t e;
        e.drive = 1'b0;
        e.data  = '0;
        case (fn)
            3'b000: begin e.drive = 1'b1; e.data = m_coni(); end
            3'b001: begin
                if (d[28]) m_done = 1'b0;
                else if (d[29]) m_done = 1'b1;
                m_busy = d[30];
                m_pia  = d[33:35];
            end
            3'b010: begin e.drive = 1'b1; e.data = m_data; m_done = 1'b0; end
            3'b011: begin m_data = d; m_done = 1'b1; m_busy = 1'b0; end
            default: ;
        endcase
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_drive"}, 36'(ebus_drive), 36'(e.drive));
            chk({tag, "_data"}, ebus_data_out, e.data);
        end
    endtask

    task automatic txn(input string tag, input logic [6:0] cs, input logic [2:0] fn,
                       input logic [0:35] d, input bit expect_xfer);
        int  cyc;
        bit  seen;
        @(negedge clk);
        ebus_cs      = cs;
        ebus_func    = fn;
        ebus_data_in = d;
        ebus_demand  = 1'b1;
        if (expect_xfer) model_commit(fn, d);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (ebus_xfer) begin
                seen = 1'b1;
                cyc  = i;
                break;
            end
        end
        chk({tag, "_xfer_seen"}, 36'(seen), 36'(expect_xfer));
        if (seen) begin
            chk({tag, "_latency"}, 36'(cyc), 36'd2);
            pop_check(tag);
        end else if (expect_xfer) begin
            void'(sb.pop_front());
        end
        ebus_demand = 1'b0;
        @(negedge clk);
        chk({tag, "_rel_xfer"}, 36'(ebus_xfer), 36'd0);
        @(negedge clk);
        chk({tag, "_idle_drive"}, {35'd0, ebus_drive} | 36'(ebus_data_out), 36'd0);
        chk({tag, "_pi"}, 36'(pi_req), 36'(m_pi()));
    endtask

    logic [0:35] w;
    bit          seen_l;

    initial begin
        rst_n        = 1'b0;
        ebus_cs      = '0;
        ebus_func    = '0;
        ebus_demand  = 1'b0;
        ebus_data_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_xfer",  36'(ebus_xfer),  36'd0);
        chk("rst_drive", 36'(ebus_drive), 36'd0);
        chk("rst_data",  ebus_data_out,   36'd0);
        chk("rst_pi",    36'(pi_req),     36'd0);
        rst_n = 1'b1;

        txn("datao1", DEV, 3'b011, 36'o123456_654321, 1'b1);
        txn("coni1",  DEV, 3'b000, 36'o0, 1'b1);
        chk("coni1_done_word", 36'o000000_000020, {30'b0, 1'b0, 1'b1, 1'b0, 3'b000});
        txn("datai1", DEV, 3'b010, 36'o0, 1'b1);
        txn("coni2",  DEV, 3'b000, 36'o0, 1'b1);

        w = '0; w[28] = 1'b1; w[29] = 1'b1; w[33:35] = 3'd5;
        txn("cono_clr_set", DEV, 3'b001, w, 1'b1);
        txn("coni3",  DEV, 3'b000, 36'o0, 1'b1);
        txn("datao2", DEV, 3'b011, 36'o000000_000777, 1'b1);
        txn("coni4",  DEV, 3'b000, 36'o0, 1'b1);

        w = '0; w[29] = 1'b1; w[30] = 1'b1; w[33:35] = 3'd7;
        txn("cono_set_busy", DEV, 3'b001, w, 1'b1);
        txn("coni5",  DEV, 3'b000, 36'o0, 1'b1);

        txn("cs_miss",  DEV + 7'd1, 3'b011, 36'o707070_070707, 1'b0);
        txn("reserved", DEV, 3'b101, 36'o707070_070707, 1'b0);
        txn("coni6",    DEV, 3'b000, 36'o0, 1'b1);
        txn("datai2",   DEV, 3'b010, 36'o0, 1'b1);

        // demand withdrawn while the responder is in LATCH
        @(negedge clk);
        ebus_cs      = DEV;
        ebus_func    = 3'b011;
        ebus_data_in = 36'o555555_555555;
        ebus_demand  = 1'b1;
        @(negedge clk);
        ebus_demand  = 1'b0;
        seen_l = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ebus_xfer) seen_l = 1'b1;
        end
        chk("latch_drop_xfer", 36'(seen_l), 36'd0);
        txn("datai3", DEV, 3'b010, 36'o0, 1'b1);

        // reset pulsed during a CONI acknowledge
        txn("datao3", DEV, 3'b011, 36'o000111_222333, 1'b1);
        @(negedge clk);
        ebus_cs     = DEV;
        ebus_func   = 3'b000;
        ebus_demand = 1'b1;
        model_commit(3'b000, 36'o0);
        seen_l = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (ebus_xfer) begin
                seen_l = 1'b1;
                break;
            end
        end
        chk("rstx_xfer_seen", 36'(seen_l), 36'd1);
        pop_check("rstx_coni");
        #1 rst_n = 1'b0;
        #1;
        chk("rstx_xfer",  36'(ebus_xfer),  36'd0);
        chk("rstx_drive", 36'(ebus_drive), 36'd0);
        chk("rstx_data",  ebus_data_out,   36'd0);
        chk("rstx_pi",    36'(pi_req),     36'd0);
        model_reset();
        ebus_demand = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        txn("coni_after_rst",  DEV, 3'b000, 36'o0, 1'b1);
        txn("datai_after_rst", DEV, 3'b010, 36'o0, 1'b1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
